morse_input_scheduler: RTL and testbench
========================================

Name: morse_input_scheduler

Overview:
- Controller in front of the Morse sequence producer. It turns raw Dot/Dash/Space/EndSeq/Clear buttons into clean, one-per-press symbol commands on the producer's 3-bit Signals bus.
- Enforces per-letter symbol limits, waits for the producer's sent handshake after EndSeq, and issues producer clears.
- Runs on the fast board clock and is gated by a tick enable from the clock divider.

Parameters:
- DEBOUNCE_TICKS, 4: consecutive ticks a button must be stable high before it counts as pressed.
- MAX_SYMS, 5: maximum dot/dash symbols per letter; further dot/dash presses are rejected.
- SENT_TIMEOUT, 15: ticks to wait for sent after EndSeq before flagging an error.
- GAP_TICKS, 30: idle ticks after the last dot/dash before an automatic Space is issued (used only with AUTO_SPACE_EN).

Ports:
- clk  in  1  system clock
- Reset  in  1  synchronous active-low reset
- tick  in  1  one-clk enable pulse from the clock divider; all timing counts in ticks
- Dot, Dash, Space, EndSeq, Clear  in  1 each  raw button levels
- sent  in  1  producer acknowledge that the sequence was delivered
- Signals  out  3  symbol command: 000 none, 001 dot, 010 dash, 011 space, 100 endseq
- prod_clear  out  1  clear pulse to producer, one clk wide
- busy  out  1  high in any state other than IDLE
- sym_count  out  3  dot/dash symbols accepted in the current letter
- err_overflow  out  1  sticky; set when a symbol is rejected because sym_count==MAX_SYMS
- err_timeout  out  1  sticky; set when sent does not arrive within SENT_TIMEOUT

Behaviour:
- Reset low at a clk edge puts every register in reset state, overriding any operation in progress:
  - Signals=000, prod_clear=0, busy=0, sym_count=0, both err flags=0.
  - FSM=IDLE, all counters 0, all button-released latches set.
- Debounce: each button has its own counter.
  - It increments on tick while the input is high and clears on tick while the input is low; it saturates at DEBOUNCE_TICKS.
  - The button is "pressed" when its count equals DEBOUNCE_TICKS and its released latch is set. Accepting a press clears the latch.
  - The latch is set again once the counter returns to 0. This guarantees exactly one event per press.
- Priority when several buttons are pressed in the same tick: Clear > EndSeq > Space > Dash > Dot. Only the winner is consumed; the lower-priority buttons keep their latches and are evaluated on later ticks.
- FSM states and transitions:
  - IDLE: on tick with a pressed button:
    - Clear -> CLR.
    - EndSeq -> ISSUE(100).
    - Space -> ISSUE(011).
    - Dash/Dot with sym_count<MAX_SYMS -> ISSUE(010/001).
    - Dash/Dot with sym_count==MAX_SYMS -> set err_overflow, consume the press, stay in IDLE.
  - ISSUE: drive the code on Signals for exactly one tick period, from the tick that entered the state to the next tick, so the divided-clock producer samples it once. Then:
    - Dot/Dash: sym_count+1, -> IDLE.
    - Space: sym_count=0, -> IDLE.
    - EndSeq: sym_count=0, -> WAIT_SENT.
  - WAIT_SENT: clear the timeout counter on entry.
    - sent=1 (sampled on any clk) -> CLR.
    - Otherwise the counter increments on each tick; when it reaches SENT_TIMEOUT, set err_timeout and -> CLR.
    - Button presses are not consumed in this state; latches are held.
  - CLR: prod_clear=1 for one clk; sym_count=0; -> IDLE.
    - A user Clear also clears err_overflow and err_timeout. Entry from WAIT_SENT leaves them unchanged.
- Signals is 000 in every state except ISSUE.
- sent arriving outside WAIT_SENT is ignored.
- If tick is held high continuously, the block behaves as if every clk were a tick.

Optional Feature:
- Macro AUTO_SPACE_EN.
- When defined:
  - A gap counter clears on every accepted Dot/Dash and increments on each tick spent in IDLE while sym_count>0.
  - When it reaches GAP_TICKS, the FSM goes to ISSUE(011) as if Space were pressed. A real button press in the same tick takes priority.
- When not defined: no gap counter is built, GAP_TICKS is unused, and Space is only issued by the button.

Test Plan:
- tick every 10 clk, DEBOUNCE_TICKS=4; hold Dot for 6 ticks, release, hold Dash for 6 ticks -> Signals shows 001 for one tick period, then 010 once; sym_count goes 1 then 2; no repeat issues while the buttons are held.
- Press Dot 6 separate times, MAX_SYMS=5 -> five 001 issues; on the 6th press no issue, err_overflow=1, sym_count stays 5.
- Press EndSeq; pulse sent 3 ticks later -> Signals=100 once, then prod_clear pulses one clk; sym_count=0; busy drops back to 0.
- Press EndSeq with sent never asserted -> after 15 ticks err_timeout=1, then prod_clear pulses; a following Clear press clears both err flags.
- Dot and Space debounced in the same tick -> Space (011) issued first, Dot (001) on a later tick; pull Reset low mid-ISSUE -> next clk all outputs 0 and FSM in IDLE.
- AUTO_SPACE_EN defined, GAP_TICKS=30: one Dot then idle -> 011 issued 30 ticks after the Dot; no auto Space when sym_count=0.

Source files
------------

// File: rtl/morse_input_scheduler.sv
// morse_input_scheduler: debounces Dot/Dash/Space/EndSeq/Clear into one-per-press producer commands.
// Define AUTO_SPACE_EN to insert a Space automatically after GAP_TICKS idle ticks inside a letter.
module morse_input_scheduler #(
   parameter int DEBOUNCE_TICKS = 4,
   parameter int MAX_SYMS = 5,
   parameter int SENT_TIMEOUT = 15
`ifdef AUTO_SPACE_EN
   , parameter int GAP_TICKS = 30
`endif
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       tick,
   input  logic       Dot,
   input  logic       Dash,
   input  logic       Space,
   input  logic       EndSeq,
   input  logic       Clear,
   input  logic       sent,
   output logic [2:0] Signals,
   output logic       prod_clear,
   output logic       busy,
   output logic [2:0] sym_count,
   output logic       err_overflow,
   output logic       err_timeout
);
   localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam int TW = $clog2(SENT_TIMEOUT + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_SENT, CLR} state_t;
   state_t state;
   logic [4:0] btn, pressed, win, take, rel;
   logic [DW-1:0] db [5];
   logic [TW-1:0] tcnt;
`ifdef AUTO_SPACE_EN
   localparam int GW = $clog2(GAP_TICKS + 1);
   logic [GW-1:0] gap;
`endif
   assign btn = {Clear, EndSeq, Space, Dash, Dot};
   always_comb begin
      pressed = '0;
      for (int i = 0; i < 5; i++) pressed[i] = (db[i] == DW'(DEBOUNCE_TICKS)) && rel[i];
   end
   assign win = pressed[4] ? 5'b10000 : pressed[3] ? 5'b01000 : pressed[2] ? 5'b00100 :
                pressed[1] ? 5'b00010 : pressed[0] ? 5'b00001 : 5'b00000;
   // only IDLE consumes presses; losers keep their latches for a later tick
   assign take = (state == IDLE && tick) ? win : 5'b00000;
   always_ff @(posedge clk) begin
      if (!Reset) begin
         for (int i = 0; i < 5; i++) db[i] <= '0;
         rel <= '1;
      end else begin
         for (int i = 0; i < 5; i++) begin
            if (tick) db[i] <= !btn[i] ? '0 : (db[i] == DW'(DEBOUNCE_TICKS)) ? db[i] : db[i] + 1'b1;
            if (take[i]) rel[i] <= 1'b0;
            else if (db[i] == '0) rel[i] <= 1'b1;
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!Reset) begin
         state <= IDLE;
         Signals <= 3'b000;
         prod_clear <= 1'b0;
         busy <= 1'b0;
         sym_count <= 3'd0;
         err_overflow <= 1'b0;
         err_timeout <= 1'b0;
         tcnt <= '0;
`ifdef AUTO_SPACE_EN
         gap <= '0;
`endif
      end else begin
         prod_clear <= 1'b0;
         case (state)
            IDLE: if (tick) begin
               if (win[4]) begin
                  state <= CLR;
                  busy <= 1'b1;
                  prod_clear <= 1'b1;
                  err_overflow <= 1'b0;
                  err_timeout <= 1'b0;
               end else if (win[3] | win[2]) begin
                  state <= ISSUE;
                  busy <= 1'b1;
                  Signals <= win[3] ? 3'b100 : 3'b011;
               end else if (win[1] | win[0]) begin
                  if (sym_count < 3'(MAX_SYMS)) begin
                     state <= ISSUE;
                     busy <= 1'b1;
                     Signals <= win[1] ? 3'b010 : 3'b001;
`ifdef AUTO_SPACE_EN
                     gap <= '0;
`endif
                  end else err_overflow <= 1'b1;
               end
`ifdef AUTO_SPACE_EN
               else if (sym_count != 3'd0) begin
                  if (gap == GW'(GAP_TICKS - 1)) begin
                     state <= ISSUE;
                     busy <= 1'b1;
                     Signals <= 3'b011;
                     gap <= '0;
                  end else gap <= gap + 1'b1;
               end
`endif
            end
            // the code is held for one full tick period so the divided-clock producer sees it once
            ISSUE: if (tick) begin
               Signals <= 3'b000;
               if (Signals == 3'b100) begin
                  state <= WAIT_SENT;
                  sym_count <= 3'd0;
                  tcnt <= '0;
               end else begin
                  state <= IDLE;
                  busy <= 1'b0;
                  sym_count <= (Signals == 3'b011) ? 3'd0 : sym_count + 3'd1;
               end
            end
            WAIT_SENT: begin
               if (sent) begin
                  state <= CLR;
                  prod_clear <= 1'b1;
               end else if (tick) begin
                  if (tcnt == TW'(SENT_TIMEOUT - 1)) begin
                     err_timeout <= 1'b1;
                     state <= CLR;
                     prod_clear <= 1'b1;
                  end else tcnt <= tcnt + 1'b1;
               end
            end
            CLR: begin
               state <= IDLE;
               busy <= 1'b0;
               sym_count <= 3'd0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_morse_input_scheduler.sv
// tb_morse_input_scheduler: table vectors, hand sequences and a randomized letter model for the scheduler.
module tb_morse_input_scheduler;
   logic clk = 1'b0;
   logic Reset, tick, Dot, Dash, Space, EndSeq, Clear, sent;
   logic [2:0] Signals, sym_count;
   logic prod_clear, busy, err_overflow, err_timeout;
   int passed = 0;
   int total = 0;
   int obs[$];
   int run = 0;
   typedef struct {
      logic [4:0] m;
      int hold;
      int code;
      int sym;
      int ovf;
   } vec_t;
   vec_t vt[9];

   morse_input_scheduler dut (
      .clk(clk), .Reset(Reset), .tick(tick), .Dot(Dot), .Dash(Dash), .Space(Space),
      .EndSeq(EndSeq), .Clear(Clear), .sent(sent), .Signals(Signals), .prod_clear(prod_clear),
      .busy(busy), .sym_count(sym_count), .err_overflow(err_overflow), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   initial begin
      tick = 1'b0;
      forever begin
         repeat (9) @(negedge clk);
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   // each nonzero Signals run is one issue; it must last exactly one tick period (10 clk)
   always @(negedge clk) begin
      if (Signals != 3'd0) begin
         if (run == 0) obs.push_back(int'(Signals));
         run++;
      end else if (run != 0) begin
         if (Reset) chk("issue_width", run, 10);
         run = 0;
      end
   end

   task automatic wait_ticks(input int n);
      for (int i = 0; i < n; i++) begin
         do @(posedge clk); while (!tick);
      end
      @(negedge clk);
   endtask

   task automatic set_btn(input logic [4:0] m);
      {Clear, EndSeq, Space, Dash, Dot} = m;
   endtask

   task automatic run_press(input string nm, input logic [4:0] m, input int hold, input int gap,
                            input int ecode, input int esym, input int eovf);
      int n0;
      n0 = obs.size();
      set_btn(m);
      wait_ticks(hold);
      set_btn(5'b0);
      wait_ticks(gap);
      chk({nm, "_issues"}, obs.size() - n0, (ecode != 0) ? 1 : 0);
      if (ecode != 0 && obs.size() > n0) chk({nm, "_code"}, obs[n0], ecode);
      chk({nm, "_sym"}, int'(sym_count), esym);
      chk({nm, "_ovf"}, int'(err_overflow), eovf);
   endtask

   initial begin
      int n0, msym, movf, k, ecode;
      logic [4:0] m;
      Reset = 1'b0;
      sent = 1'b0;
      set_btn(5'b0);
      vt[0] = '{5'b00001, 6, 1, 1, 0};
      vt[1] = '{5'b00010, 6, 2, 2, 0};
      vt[2] = '{5'b00100, 7, 3, 0, 0};
      vt[3] = '{5'b00001, 6, 1, 1, 0};
      vt[4] = '{5'b00001, 8, 1, 2, 0};
      vt[5] = '{5'b00010, 6, 2, 3, 0};
      vt[6] = '{5'b00001, 5, 1, 4, 0};
      vt[7] = '{5'b00001, 6, 1, 5, 0};
      vt[8] = '{5'b00001, 6, 0, 5, 1};
      repeat (3) @(negedge clk);
      chk("rst_signals", int'(Signals), 0);
      chk("rst_prod_clear", int'(prod_clear), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sym", int'(sym_count), 0);
      chk("rst_ovf", int'(err_overflow), 0);
      chk("rst_tmo", int'(err_timeout), 0);
      Reset = 1'b1;
      wait_ticks(2);
      for (int i = 0; i < 9; i++)
         run_press($sformatf("vec%0d", i), vt[i].m, vt[i].hold, 4, vt[i].code, vt[i].sym, vt[i].ovf);
      // sent outside WAIT_SENT must not trigger a producer clear
      sent = 1'b1;
      @(negedge clk);
      sent = 1'b0;
      chk("stray_sent_clr", int'(prod_clear), 0);
      chk("stray_sent_busy", int'(busy), 0);
      // EndSeq with sent three ticks later
      n0 = obs.size();
      set_btn(5'b01000);
      wait_ticks(6);
      set_btn(5'b0);
      chk("end_issues", obs.size() - n0, 1);
      if (obs.size() > n0) chk("end_code", obs[n0], 4);
      chk("end_busy", int'(busy), 1);
      chk("end_sym", int'(sym_count), 0);
      wait_ticks(3);
      sent = 1'b1;
      @(negedge clk);
      sent = 1'b0;
      chk("sent_clr_hi", int'(prod_clear), 1);
      @(negedge clk);
      chk("sent_clr_lo", int'(prod_clear), 0);
      chk("sent_busy", int'(busy), 0);
      chk("sent_sym", int'(sym_count), 0);
      chk("sent_tmo", int'(err_timeout), 0);
      wait_ticks(4);
      // EndSeq with no sent: timeout on the 15th tick
      set_btn(5'b01000);
      wait_ticks(6);
      set_btn(5'b0);
      wait_ticks(14);
      chk("tmo_early", int'(err_timeout), 0);
      chk("tmo_early_busy", int'(busy), 1);
      wait_ticks(1);
      chk("tmo_flag", int'(err_timeout), 1);
      chk("tmo_clr_hi", int'(prod_clear), 1);
      chk("tmo_ovf_kept", int'(err_overflow), 1);
      @(negedge clk);
      chk("tmo_clr_lo", int'(prod_clear), 0);
      chk("tmo_busy", int'(busy), 0);
      wait_ticks(4);
      set_btn(5'b10000);
      wait_ticks(5);
      chk("uclr_pulse", int'(prod_clear), 1);
      chk("uclr_ovf", int'(err_overflow), 0);
      chk("uclr_tmo", int'(err_timeout), 0);
      set_btn(5'b0);
      wait_ticks(4);
      chk("uclr_busy", int'(busy), 0);
      // Space and Dot debounced together: Space wins, Dot follows
      n0 = obs.size();
      set_btn(5'b00101);
      wait_ticks(6);
      set_btn(5'b0);
      wait_ticks(4);
      chk("prio_issues", obs.size() - n0, 2);
      if (obs.size() >= n0 + 2) begin
         chk("prio_first", obs[n0], 3);
         chk("prio_second", obs[n0 + 1], 1);
      end
      chk("prio_sym", int'(sym_count), 1);
      // reset in the middle of an issue
      set_btn(5'b00001);
      wait_ticks(5);
      chk("mid_sig", int'(Signals), 1);
      chk("mid_busy", int'(busy), 1);
      Reset = 1'b0;
      @(negedge clk);
      set_btn(5'b0);
      chk("mid_rst_sig", int'(Signals), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_sym", int'(sym_count), 0);
      chk("mid_rst_clr", int'(prod_clear), 0);
      @(negedge clk);
      Reset = 1'b1;
      wait_ticks(4);
      // random letters against a symbol-count model
      msym = 0;
      movf = 0;
      for (int i = 0; i < 30; i++) begin
         k = $urandom_range(0, 3);
         m = (k == 1) ? 5'b00010 : (k == 2) ? 5'b00100 : 5'b00001;
         if (k == 2) begin
            ecode = 3;
            msym = 0;
         end else if (msym < 5) begin
            ecode = (k == 1) ? 2 : 1;
            msym++;
         end else begin
            ecode = 0;
            movf = 1;
         end
         run_press($sformatf("rnd%0d", i), m, $urandom_range(5, 8), $urandom_range(4, 6), ecode, msym, movf);
      end
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
